// File: rtl/print_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : print_uart_tx
// Brief    : Byte FIFO feeding an 8N1 UART transmitter for a core print path.
// Revision : 1.0
// ============================================================================
module print_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          print_valid,
    input  logic [7:0]                    print_value,
    input  logic                          ovf_clear,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int              c_AW       = $clog2(FIFO_DEPTH);
    localparam int              c_CW       = c_AW + 1;
    localparam logic [c_CW-1:0] c_FULL     = c_CW'(FIFO_DEPTH);
    localparam logic [15:0]     c_BAUD_MAX = 16'(CLKS_PER_BIT - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic            r_overflow;
    logic            r_tx;
    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [15:0]     r_baud;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;

    logic            w_fifo_nonempty;
    logic            w_push;
    logic            w_drop;
    logic            w_pop;
    logic            w_bit_done;
    logic            w_tx_next;
    logic [2:0]      w_bit_next;

    assign w_fifo_nonempty = (r_count != '0);
    // A full FIFO refuses the byte even when a pop frees a slot on the same edge.
    assign w_push          = print_valid && (r_count != c_FULL);
    assign w_drop          = print_valid && (r_count == c_FULL);
    assign w_bit_done      = (r_baud == c_BAUD_MAX);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= print_value;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clear) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_fifo_nonempty) begin
                    w_next_state = c_START;
                end
            end
            c_START: begin
                if (w_bit_done) begin
                    w_next_state = c_DATA;
                end
            end
            c_DATA: begin
                if (w_bit_done && (r_bit_idx == 3'd7)) begin
                    w_next_state = c_STOP;
                end
            end
            c_STOP: begin
                if (w_bit_done) begin
                    w_next_state = w_fifo_nonempty ? c_START : c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // The line value is computed for the next state so uart_tx can be a plain flop.
    always_comb begin
        w_pop      = 1'b0;
        w_bit_next = 3'd0;
        w_tx_next  = 1'b1;
        if (((r_state == c_IDLE) || ((r_state == c_STOP) && w_bit_done)) && w_fifo_nonempty) begin
            w_pop = 1'b1;
        end
        if (r_state == c_DATA) begin
            w_bit_next = w_bit_done ? (r_bit_idx + 3'd1) : r_bit_idx;
        end
        case (w_next_state)
            c_START: w_tx_next = 1'b0;
            c_DATA:  w_tx_next = r_shift[w_bit_next];
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            if ((w_next_state != r_state) || ((r_state == c_DATA) && w_bit_done)) begin
                r_baud <= '0;
            end else if (r_state != c_IDLE) begin
                r_baud <= r_baud + 16'd1;
            end
            r_bit_idx <= w_bit_next;
            if (w_pop) begin
                r_shift <= r_mem[r_rd_ptr];
            end
            r_tx <= w_tx_next;
        end
    end

    assign uart_tx    = r_tx;
    assign busy       = (r_state != c_IDLE) || w_fifo_nonempty;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_print_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_print_uart_tx
// Brief    : Randomised bench for print_uart_tx against a frame-timing model.
// Revision : 1.0
// ============================================================================
module tb_print_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk         = 1'b0;
    logic       resetn      = 1'b0;
    logic       print_valid = 1'b0;
    logic [7:0] print_value = 8'h00;
    logic       ovf_clear   = 1'b0;
    logic       uart_tx;
    logic       busy;
    logic [2:0] fifo_count;
    logic       overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    print_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .print_valid (print_valid),
        .print_value (print_value),
        .ovf_clear   (ovf_clear),
        .uart_tx     (uart_tx),
        .busy        (busy),
        .fifo_count  (fifo_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Reference: a byte queue plus the edge number at which the current frame began.
    int         m_cyc       = 0;
    int         m_next_free = 0;
    int         m_start     = -1000;
    logic [7:0] m_q[$];
    logic [7:0] m_cur       = 8'h00;
    logic       m_ovf       = 1'b0;
    bit         m_do_pop;
    bit         m_do_push;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_q.delete();
            m_cyc       = 0;
            m_next_free = 0;
            m_start     = -1000;
            m_ovf       = 1'b0;
            m_cur       = 8'h00;
        end else begin
            m_cyc     = m_cyc + 1;
            m_do_pop  = (m_q.size() != 0) && (m_cyc >= m_next_free);
            m_do_push = print_valid && (m_q.size() < DEPTH);
            if (print_valid && !m_do_push) m_ovf = 1'b1;
            else if (ovf_clear)            m_ovf = 1'b0;
            if (m_do_pop) begin
                m_cur       = m_q.pop_front();
                m_start     = m_cyc;
                m_next_free = m_cyc + FRAME;
            end
            if (m_do_push) m_q.push_back(print_value);
        end
    end

    function automatic logic [5:0] exp_vec();
        logic act;
        logic tx;
        int   off;
        act = (m_cyc < m_next_free);
        off = m_cyc - m_start;
        if (!act)                tx = 1'b1;
        else if (off < CPB)      tx = 1'b0;
        else if (off < 9 * CPB)  tx = m_cur[3'((off - CPB) / CPB)];
        else                     tx = 1'b1;
        return {tx, act || (m_q.size() != 0), 3'(m_q.size()), m_ovf};
    endfunction

    function automatic logic [5:0] got();
        return {uart_tx, busy, fifo_count, overflow};
    endfunction

    task automatic tick(input logic v, input logic [7:0] val, input logic clr);
        print_valid = v;
        print_value = val;
        ovf_clear   = clr;
        @(negedge clk);
        print_valid = 1'b0;
        ovf_clear   = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] b;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (got() !== 6'b1_0_000_0) begin
            n_fail++;
            $display("FAIL reset_state: got {tx,busy,cnt,ovf}=%b required=%b", got(), 6'b100000);
        end
        resetn = 1'b1;
        b = 8'($urandom_range(0, 255));
        tick(1'b1, b, 1'b0);
        n_cmp++;
        if (fifo_count !== 3'd1) begin
            n_fail++;
            $display("FAIL first_edge_push: got cnt=%0d required=1", fifo_count);
        end
        repeat (FRAME + 5) begin
            tick(1'b0, 8'h00, 1'b0);
            n_cmp++;
            if (got() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_frame t=%0t: got %b required %b", $time, got(), exp_vec());
            end
        end
    endtask

    task automatic test_single();
        tick(1'b1, 8'h41, 1'b0);
        n_cmp++;
        if (got() !== exp_vec()) begin
            n_fail++;
            $display("FAIL single_push t=%0t: got %b required %b", $time, got(), exp_vec());
        end
        repeat (FRAME + 4) begin
            tick(1'b0, 8'h00, 1'b0);
            n_cmp++;
            if (got() !== exp_vec()) begin
                n_fail++;
                $display("FAIL single_frame t=%0t: got %b required %b", $time, got(), exp_vec());
            end
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: got busy=%b required 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int low_cycles = 0;
        tick(1'b1, 8'h55, 1'b0);
        tick(1'b1, 8'hAA, 1'b0);
        repeat (2 * FRAME + 4) begin
            if (uart_tx === 1'b0) low_cycles++;
            n_cmp++;
            if (got() !== exp_vec()) begin
                n_fail++;
                $display("FAIL b2b_frame t=%0t: got %b required %b", $time, got(), exp_vec());
            end
            tick(1'b0, 8'h00, 1'b0);
        end
        // 0x55 and 0xAA each carry four zero bits plus a start bit.
        n_cmp++;
        if (low_cycles !== 10 * CPB) begin
            n_fail++;
            $display("FAIL b2b_low_cycles: got %0d required %0d", low_cycles, 10 * CPB);
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 6; i++) begin
            tick(1'b1, 8'(i), 1'b0);
            n_cmp++;
            if (got() !== exp_vec()) begin
                n_fail++;
                $display("FAIL ovf_fill t=%0t: got %b required %b", $time, got(), exp_vec());
            end
        end
        n_cmp++;
        if ({fifo_count, overflow} !== {3'd4, 1'b1}) begin
            n_fail++;
            $display("FAIL ovf_full: got cnt=%0d ovf=%b required cnt=4 ovf=1", fifo_count, overflow);
        end
        tick(1'b1, 8'h77, 1'b1);
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set_wins: got ovf=%b required 1", overflow);
        end
        tick(1'b0, 8'h00, 1'b1);
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got ovf=%b required 0", overflow);
        end
        repeat (5 * FRAME + 5) begin
            tick(1'b0, 8'h00, 1'b0);
            n_cmp++;
            if (got() !== exp_vec()) begin
                n_fail++;
                $display("FAIL ovf_drain t=%0t: got %b required %b", $time, got(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        tick(1'b1, 8'h3C, 1'b0);
        tick(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        tick(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        repeat (4 * CPB) tick(1'b0, 8'h00, 1'b0);
        n_cmp++;
        if ({busy, fifo_count, uart_tx} !== {1'b1, 3'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_frame_pre: got busy=%b cnt=%0d tx=%b required 1/2/1", busy, fifo_count, uart_tx);
        end
        #2 resetn = 1'b0;
        #1;
        n_cmp++;
        if (got() !== 6'b1_0_000_0) begin
            n_fail++;
            $display("FAIL async_reset: got %b required %b", got(), 6'b100000);
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (3 * FRAME) begin
            tick(1'b0, 8'h00, 1'b0);
            n_cmp++;
            if (got() !== exp_vec() || uart_tx !== 1'b1) begin
                n_fail++;
                $display("FAIL post_reset_quiet t=%0t: got %b required %b", $time, got(), exp_vec());
            end
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 8'($urandom_range(0, 255)), 1'b0);
            repeat (44) begin
                n_cmp++;
                if (got() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL wrap_byte%0d t=%0t: got %b required %b", i, $time, got(), exp_vec());
                end
                tick(1'b0, 8'h00, 1'b0);
            end
        end
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_no_ovf: got ovf=%b required 0", overflow);
        end
    endtask

    task automatic test_random();
        int rate;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) rate = int'($urandom_range(2, 60));
            tick(($urandom_range(0, rate - 1) == 0), 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 15) == 0));
            n_cmp++;
            if (got() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random t=%0t: got %b required %b", $time, got(), exp_vec());
            end
        end
        repeat (5 * FRAME + 5) begin
            tick(1'b0, 8'h00, 1'b0);
            n_cmp++;
            if (got() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_drain t=%0t: got %b required %b", $time, got(), exp_vec());
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/print_uart_tx.md
PRINT_UART_TX -- requirements
Module: print_uart_tx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (legal range 2..65535).
REQ-002 SHALL provide parameter FIFO_DEPTH, default 16, meaning byte entries in the print FIFO (power of two, 2..256).
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port print_valid  input  1  one-cycle strobe: print_value holds a character.
REQ-006 SHALL have port print_value  input  8  character from the core print path.
REQ-007 SHALL have port ovf_clear  input  1  synchronous clear of the overflow flag.
REQ-008 SHALL have port uart_tx  output  1  serial line, 8N1, LSB first, idle high.
REQ-009 SHALL have port busy  output  1  high while a frame is in progress or the FIFO is non-empty.
REQ-010 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  number of bytes queued, excluding the byte on the line.
REQ-011 SHALL have port overflow  output  1  sticky flag: a character was dropped.

Function
REQ-012 SHALL push print_value into the FIFO on any edge where print_valid=1 and fifo_count<FIFO_DEPTH.
REQ-013 SHALL drop the character and set overflow when print_valid=1 and fifo_count==FIFO_DEPTH, even if a pop occurs on the same edge.
REQ-014 SHALL clear overflow when ovf_clear=1, unless a drop occurs on the same edge, in which case overflow stays 1 (set wins).
REQ-015 SHALL use simultaneous push and pop on a non-full FIFO to leave fifo_count unchanged and keep data order intact.
REQ-016 SHALL wrap read and write pointers modulo FIFO_DEPTH without losing or duplicating entries.
REQ-017 SHALL implement the FSM states IDLE, START, DATA, STOP.
REQ-018 SHALL in IDLE: uart_tx=1; when fifo_count>0, pop the head byte into the shift register and go to START on the same edge.
REQ-019 SHALL in START: uart_tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
REQ-020 SHALL in DATA: uart_tx=shift[bit index] for CLKS_PER_BIT cycles per bit, bits 0..7, then go to STOP.
REQ-021 SHALL in STOP: uart_tx=1 for CLKS_PER_BIT cycles. At the end, if fifo_count>0, pop and go directly to START with no idle gap; otherwise go to IDLE.
REQ-022 SHALL register uart_tx, with no combinational path from any input to uart_tx.
REQ-023 SHALL make each frame exactly 10*CLKS_PER_BIT cycles long.
REQ-024 SHALL use a baud counter that reloads on every state or bit change and never drifts across frames.
REQ-025 SHALL have latency: if print_valid is sampled at edge E0 with FSM in IDLE and the FIFO empty, fifo_count=1 after E0, and uart_tx=0 after E0+1 with fifo_count=0.
REQ-026 SHALL compute busy as (state!=IDLE) or (fifo_count>0).

Reset
REQ-027 SHALL, on resetn=0 at any time including mid-frame, immediately force uart_tx=1, busy=0, fifo_count=0, overflow=0, state=IDLE, pointers=0, baud counter=0 and bit index=0.
REQ-028 SHALL discard FIFO contents and any partial frame on reset, and not resume the frame after reset release.
REQ-029 SHALL accept print_valid on the first rising edge after resetn deasserts.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-030 SHALL cover: single byte 0x41 -> uart_tx low 1 cycle after the push edge, then bits 1,0,0,0,0,0,1,0 at 4 cycles each, stop high 4 cycles, 40-cycle frame, busy low afterwards.
REQ-031 SHALL cover: bytes 0x55 then 0xAA on consecutive cycles -> two back-to-back frames, 80 cycles total, no idle cycle between stop and start.
REQ-032 SHALL cover: 6 strobes on consecutive cycles, 0x01..0x06 -> byte 0x01 on the line, 0x02..0x05 queued with fifo_count=4, 0x06 dropped with overflow=1; output is 0x01..0x05 in order.
REQ-033 SHALL cover: overflow=1, then ovf_clear and a dropped push on the same edge -> overflow remains 1; ovf_clear alone on the next edge -> overflow=0.
REQ-034 SHALL cover: resetn pulsed low during DATA bit 3 of 0x3C with 2 bytes queued -> uart_tx=1, fifo_count=0 and busy=0 asynchronously; no further frames after release.
REQ-035 SHALL cover: 12 bytes pushed one every 45 cycles -> pointers wrap 3 times, all 12 bytes received in order, overflow=0.
